// File: rtl/spi_master_p.sv
// Parametrised SPI master with configurable frame length, slave selects, CPOL/CPHA
// and bit order; receives the whole frame full-duplex and reports it on completion.
module spi_master_p #(
    parameter int DATA_W     = 32,
    parameter int NUM_SS     = 4,
    parameter int PRESCALE_W = 24,
    parameter int LEN_W      = $clog2(DATA_W),
    parameter int SEL_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  turnon,
    input  logic                  start,
    input  logic [DATA_W-1:0]     din,
    input  logic [LEN_W-1:0]      len,
    input  logic [SEL_W-1:0]      select,
    input  logic                  order,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [NUM_SS-1:0]     ss_n,
    output logic [DATA_W-1:0]     dout,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [LEN_W:0]        edge_q, edge_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  done_q, done_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  order_q, order_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;

    logic                  tick;
    logic [LEN_W-1:0]      bit_idx;
    logic [LEN_W-1:0]      pos;
    logic                  last_edge;

    // Maps the n-th bit on the wire to its position in din/dout.
    function automatic logic [LEN_W-1:0] bit_pos(input logic ord, input logic [LEN_W-1:0] l,
                                                 input logic [LEN_W-1:0] idx);
        return ord ? idx : l - idx;
    endfunction

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (sel == SEL_W'(i)) r[i] = 1'b0;
        return r;
    endfunction

    assign tick      = (cnt_q == pre_q);
    assign bit_idx   = edge_q[LEN_W:1];
    assign pos       = bit_pos(order_q, len_q, bit_idx);
    assign last_edge = (edge_q == {len_q, 1'b1});

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ss_n_d  = ss_n_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        din_d   = din_q;
        len_d   = len_q;
        sel_d   = sel_q;
        order_d = order_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        pre_d   = pre_q;

        if (!turnon) begin
            state_d = IDLE;
            cnt_d   = '0;
            edge_d  = '0;
            sck_d   = cpol;
            mosi_d  = 1'b1;
            ss_n_d  = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    edge_d = '0;
                    sck_d  = cpol;
                    mosi_d = 1'b1;
                    ss_n_d = '1;
                    if (start) begin
                        state_d = SETUP;
                        din_d   = din;
                        len_d   = len;
                        sel_d   = select;
                        order_d = order;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        pre_d   = prescale;
                        rx_d    = '0;
                        ss_n_d  = ss_decode(select);
                        if (!cpha) mosi_d = din[bit_pos(order, len, '0)];
                    end
                end
                SETUP: begin
                    cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
                    if (tick) state_d = SHIFT;
                end
                SHIFT: begin
                    cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
                    if (tick) begin
                        sck_d  = ~sck_q;
                        edge_d = edge_q + (LEN_W+1)'(1);
                        // Even edge_q is a leading edge, odd is trailing.
                        if (edge_q[0] == cpha_q) begin
                            rx_d[pos] = miso;
                        end else if (cpha_q) begin
                            mosi_d = din_q[pos];
                        end else if (!last_edge) begin
                            mosi_d = din_q[bit_pos(order_q, len_q, bit_idx + LEN_W'(1))];
                        end
                        if (last_edge) begin
                            state_d = HOLD;
                            edge_d  = '0;
                        end
                    end
                end
                HOLD: begin
                    cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
                    if (tick) begin
                        state_d = IDLE;
                        sck_d   = cpol;
                        mosi_d  = 1'b1;
                        ss_n_d  = '1;
                        done_d  = 1'b1;
                        dout_d  = rx_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            ss_n_q  <= '1;
            rx_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            din_q   <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            order_q <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            din_q   <= din_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            order_q <= order_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            pre_q   <= pre_d;
        end
    end

    assign mosi = mosi_q;
    assign sck  = sck_q;
    assign ss_n = ss_n_q;
    assign dout = dout_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_spi_master_p.sv
// Self-checking bench for spi_master_p: directed scenarios plus random frames
// checked against a behavioural SPI slave and an arithmetic frame model.
module tb_spi_master_p;

    localparam int DATA_W     = 32;
    localparam int NUM_SS     = 4;
    localparam int PRESCALE_W = 24;
    localparam int LEN_W      = 5;
    localparam int SEL_W      = 2;

    logic                  clk = 1'b0;
    logic                  nrst = 1'b1;
    logic                  turnon = 1'b0;
    logic                  start = 1'b0;
    logic [DATA_W-1:0]     din = '0;
    logic [LEN_W-1:0]      len = '0;
    logic [SEL_W-1:0]      select = '0;
    logic                  order = 1'b0;
    logic                  cpol = 1'b0;
    logic                  cpha = 1'b0;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic                  miso;
    logic                  mosi;
    logic                  sck;
    logic [NUM_SS-1:0]     ss_n;
    logic [DATA_W-1:0]     dout;
    logic                  busy;
    logic                  done;

    logic loopback = 1'b0;
    logic slave_miso = 1'b1;
    assign miso = loopback ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_master_p #(
        .DATA_W(DATA_W), .NUM_SS(NUM_SS), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk), .nrst(nrst), .turnon(turnon), .start(start), .din(din),
        .len(len), .select(select), .order(order), .cpol(cpol), .cpha(cpha),
        .prescale(prescale), .miso(miso), .mosi(mosi), .sck(sck), .ss_n(ss_n),
        .dout(dout), .busy(busy), .done(done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave and bus monitor, sampled just after each rising clk edge.
    int                busy_cyc, done_cnt, rise_cnt, tog_cnt, ss_bad, cap_n, s_idx, s_len;
    logic [NUM_SS-1:0] exp_ss = '1;
    logic [31:0]       s_word;
    logic              s_cpol, s_cpha, s_order, lead;
    logic [63:0]       cap;
    logic              sck_p = 1'b0, busy_p = 1'b0;

    function automatic logic s_bit(input int i);
        if (i > s_len) return 1'b1;
        return s_order ? s_word[i] : s_word[s_len-i];
    endfunction

    always @(posedge clk) begin
        #1;
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && ss_n !== exp_ss) ss_bad++;
        if (busy !== 1'b1 && ss_n !== {NUM_SS{1'b1}}) ss_bad++;
        if (busy === 1'b1 && busy_p !== 1'b1) begin
            s_idx = 0;
            if (!s_cpha) slave_miso = s_bit(0);
        end else if (busy === 1'b1 && busy_p === 1'b1 && sck !== sck_p) begin
            tog_cnt++;
            if (sck === 1'b1) rise_cnt++;
            lead = (sck != s_cpol);
            if (lead != s_cpha) begin
                if (cap_n < 64) cap[cap_n] = mosi;
                cap_n++;
                if (s_cpha) s_idx++;
            end else if (s_cpha) begin
                slave_miso = s_bit(s_idx);
            end else begin
                s_idx++;
                slave_miso = s_bit(s_idx);
            end
        end
        sck_p  = sck;
        busy_p = busy;
    end

    logic [31:0] cur_din, cur_word;
    int          cur_len, cur_pre;
    logic        cur_ord;
    logic [63:0] last_dout = '0;

    // Called on a falling clk edge; returns one falling edge after start was taken.
    task automatic launch(input logic [31:0] d, input logic [31:0] w, input int l, input int sel,
                          input int ord, input int pol, input int pha, input int pre);
        din      = d;
        len      = LEN_W'(l);
        select   = SEL_W'(sel);
        order    = ord[0];
        cpol     = pol[0];
        cpha     = pha[0];
        prescale = PRESCALE_W'(pre);
        cur_din  = d;
        cur_word = w;
        cur_len  = l;
        cur_pre  = pre;
        cur_ord  = ord[0];
        s_word   = w;
        s_len    = l;
        s_order  = ord[0];
        s_cpol   = pol[0];
        s_cpha   = pha[0];
        exp_ss   = '1;
        exp_ss[sel] = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        rise_cnt = 0;
        tog_cnt  = 0;
        ss_bad   = 0;
        cap      = '0;
        cap_n    = 0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_toggles(input int n);
        int k = 0;
        while (tog_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("toggle_wait", tog_cnt >= n, 1'b1);
    endtask

    // Expected frame computed from the wire-order rules, not from the design.
    task automatic frame_check(input string tag);
        logic [63:0] exp_mosi = '0;
        logic [63:0] mask;
        logic [63:0] exp_dout;
        mask = (64'd1 << (cur_len + 1)) - 64'd1;
        for (int i = 0; i <= cur_len; i++)
            exp_mosi[i] = cur_ord ? cur_din[i] : cur_din[cur_len-i];
        exp_dout = (loopback ? {32'd0, cur_din} : {32'd0, cur_word}) & mask;
        check({tag, "_dout"}, {32'd0, dout}, exp_dout);
        check({tag, "_busy_cycles"}, busy_cyc, (2*cur_len + 4) * (cur_pre + 1));
        check({tag, "_mosi_bits"}, cap, exp_mosi);
        check({tag, "_mosi_count"}, cap_n, cur_len + 1);
        check({tag, "_sck_rises"}, rise_cnt, cur_len + 1);
        check({tag, "_ss_n_bad"}, ss_bad, 0);
        last_dout = exp_dout;
    endtask

    initial begin
        #1 nrst = 1'b0;
        #2;
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b1);
        check("rst_dout", dout, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        nrst   = 1'b1;
        turnon = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, MSB-first, loopback.
        loopback = 1'b1;
        launch(32'hA5, 32'h0, 7, 0, 0, 0, 0, 1);
        check("t1_busy_rise", busy, 1'b1);
        wait_done("t1");
        frame_check("t1");
        repeat (5) @(negedge clk);
        check("t1_one_done", done_cnt, 1);
        loopback = 1'b0;

        // Mode 3, LSB-first, full 32-bit frame at clk/2.
        launch(32'h12345678, 32'hCAFEF00D, 31, 0, 1, 1, 1, 0);
        wait_done("t2");
        frame_check("t2");
        @(negedge clk);
        check("t2_sck_idle_high", sck, 1'b1);

        // start re-pulsed with new data mid-frame is ignored.
        launch(32'h3C, 32'h5A, 7, 1, 0, 0, 1, 2);
        repeat (10) @(negedge clk);
        din   = 32'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3");
        frame_check("t3");
        repeat (20) @(negedge clk);
        check("t3_one_done", done_cnt, 1);
        check("t3_no_second", busy, 1'b0);

        // Abort with turnon low at the 5th sck edge.
        launch(32'h96, 32'h69, 7, 0, 0, 1, 0, 1);
        wait_toggles(5);
        turnon = 1'b0;
        @(posedge clk);
        #2;
        check("t4_ss_n", ss_n, 4'hF);
        check("t4_busy", busy, 1'b0);
        check("t4_sck_cpol", sck, 1'b1);
        check("t4_dout_kept", {32'd0, dout}, last_dout);
        repeat (5) @(negedge clk);
        check("t4_no_done", done_cnt, 0);
        turnon = 1'b1;
        @(negedge clk);

        // Back-to-back: second start lands in the done cycle.
        launch(32'h81, 32'h7E, 7, 0, 0, 0, 0, 1);
        wait_done("t5a");
        check("t5_gap_busy", busy, 1'b0);
        frame_check("t5a");
        launch(32'hC3, 32'h1B, 7, 2, 0, 0, 1, 1);
        check("t5_busy_next", busy, 1'b1);
        check("t5_ss_n", ss_n, 4'b1011);
        wait_done("t5b");
        frame_check("t5b");
        @(negedge clk);

        // Shortest frame: a single bit.
        launch(32'h1, 32'h0, 0, 3, 0, 0, 1, 3);
        wait_done("len0");
        frame_check("len0");
        @(negedge clk);

        // Random frames against the slave model.
        for (int t = 0; t < 6; t++) begin
            launch($urandom, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            wait_done("rnd");
            frame_check("rnd");
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        // Asynchronous reset in the middle of SHIFT.
        launch(32'h0F0F1234, 32'hBEEF, 23, 1, 1, 1, 1, 1);
        wait_toggles(3);
        #3 nrst = 1'b0;
        #1;
        check("t6_ss_n", ss_n, 4'hF);
        check("t6_sck", sck, 1'b0);
        check("t6_mosi", mosi, 1'b1);
        check("t6_dout", dout, 32'd0);
        check("t6_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_sck_follows_cpol", sck, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
